// File: rtl/n101_tl_defines.sv
// Shared TileLink-UL opcode constants and the bridge state encoding used by
// the TileLink-to-ICB bridge.
package n101_tl_defines;

   // A-channel request opcodes
   localparam logic [2:0] TL_PUTFULL = 3'd0;
   localparam logic [2:0] TL_PUTPART = 3'd1;
   localparam logic [2:0] TL_GET     = 3'd4;

   // D-channel response opcodes
   localparam logic [2:0] TL_ACK     = 3'd0;
   localparam logic [2:0] TL_ACKDATA = 3'd1;

   // Largest supported transfer is one 32-bit word (log2 bytes)
   localparam logic [2:0] TL_MAX_SIZE = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_RSP  = 2'd2,
      ST_DRSP = 2'd3
   } bridge_state_e;

   // A request is forwarded to ICB only for Get/Put of at most one word
   function automatic logic tl_supported(input logic [2:0] opcode, input logic [2:0] size);
      return ((opcode == TL_PUTFULL) || (opcode == TL_PUTPART) || (opcode == TL_GET))
             && (size <= TL_MAX_SIZE);
   endfunction

   // ICB byte-lane mask derived from the TileLink opcode
   function automatic logic [3:0] tl_wmask(input logic [2:0] opcode, input logic [3:0] mask);
      logic [3:0] result;
      result = 4'h0;
      if (opcode == TL_PUTFULL) begin
         result = 4'hF;
      end else if (opcode == TL_PUTPART) begin
         result = mask;
      end
      return result;
   endfunction

endpackage

// File: rtl/n101_tl2icb_bridge_if.sv
// Bundle of the TileLink A/D channel pair and the ICB initiator port.
// The slave modport is the bridge's view; the master modport is the view of
// the environment (TileLink master plus ICB target).
interface n101_tl2icb_bridge_if #(
   parameter int SRC_W      = 5,
   parameter int ICB_ADDR_W = 32
);

   logic                  io_in_0_a_valid;
   logic                  io_in_0_a_ready;
   logic [2:0]            io_in_0_a_bits_opcode;
   logic [2:0]            io_in_0_a_bits_param;
   logic [2:0]            io_in_0_a_bits_size;
   logic [SRC_W-1:0]      io_in_0_a_bits_source;
   logic [28:0]           io_in_0_a_bits_address;
   logic [3:0]            io_in_0_a_bits_mask;
   logic [31:0]           io_in_0_a_bits_data;

   logic                  io_in_0_d_valid;
   logic                  io_in_0_d_ready;
   logic [2:0]            io_in_0_d_bits_opcode;
   logic [1:0]            io_in_0_d_bits_param;
   logic [2:0]            io_in_0_d_bits_size;
   logic [SRC_W-1:0]      io_in_0_d_bits_source;
   logic                  io_in_0_d_bits_sink;
   logic [1:0]            io_in_0_d_bits_addr_lo;
   logic [31:0]           io_in_0_d_bits_data;
   logic                  io_in_0_d_bits_error;

   logic                  o_icb_cmd_valid;
   logic                  o_icb_cmd_ready;
   logic [ICB_ADDR_W-1:0] o_icb_cmd_addr;
   logic                  o_icb_cmd_read;
   logic [31:0]           o_icb_cmd_wdata;
   logic [3:0]            o_icb_cmd_wmask;
   logic                  o_icb_rsp_valid;
   logic                  o_icb_rsp_ready;
   logic [31:0]           o_icb_rsp_rdata;
   logic                  o_icb_rsp_err;

   modport slave (
      input  io_in_0_a_valid, io_in_0_a_bits_opcode, io_in_0_a_bits_param,
             io_in_0_a_bits_size, io_in_0_a_bits_source, io_in_0_a_bits_address,
             io_in_0_a_bits_mask, io_in_0_a_bits_data, io_in_0_d_ready,
             o_icb_cmd_ready, o_icb_rsp_valid, o_icb_rsp_rdata, o_icb_rsp_err,
      output io_in_0_a_ready, io_in_0_d_valid, io_in_0_d_bits_opcode,
             io_in_0_d_bits_param, io_in_0_d_bits_size, io_in_0_d_bits_source,
             io_in_0_d_bits_sink, io_in_0_d_bits_addr_lo, io_in_0_d_bits_data,
             io_in_0_d_bits_error, o_icb_cmd_valid, o_icb_cmd_addr, o_icb_cmd_read,
             o_icb_cmd_wdata, o_icb_cmd_wmask, o_icb_rsp_ready
   );

   modport master (
      output io_in_0_a_valid, io_in_0_a_bits_opcode, io_in_0_a_bits_param,
             io_in_0_a_bits_size, io_in_0_a_bits_source, io_in_0_a_bits_address,
             io_in_0_a_bits_mask, io_in_0_a_bits_data, io_in_0_d_ready,
             o_icb_cmd_ready, o_icb_rsp_valid, o_icb_rsp_rdata, o_icb_rsp_err,
      input  io_in_0_a_ready, io_in_0_d_valid, io_in_0_d_bits_opcode,
             io_in_0_d_bits_param, io_in_0_d_bits_size, io_in_0_d_bits_source,
             io_in_0_d_bits_sink, io_in_0_d_bits_addr_lo, io_in_0_d_bits_data,
             io_in_0_d_bits_error, o_icb_cmd_valid, o_icb_cmd_addr, o_icb_cmd_read,
             o_icb_cmd_wdata, o_icb_cmd_wmask, o_icb_rsp_ready
   );

endinterface

// File: rtl/n101_tl2icb_bridge.sv
// TileLink-UL to ICB bridge: accepts one A request at a time, issues at most
// one ICB command for it, and returns exactly one D response. Every output is
// driven straight from a register so fields stay stable under backpressure.
module n101_tl2icb_bridge
   import n101_tl_defines::*;
#(
   parameter int ICB_ADDR_W = 32,
   parameter int SRC_W      = 5
) (
   input logic               clock,
   input logic               reset,
   n101_tl2icb_bridge_if.slave bus
);

   bridge_state_e         state;

   logic                  a_ready_q;
   logic                  cmd_valid_q;
   logic                  rsp_ready_q;
   logic                  d_valid_q;

   logic [28:0]           addr_q;
   logic                  cmd_read_q;
   logic [31:0]           cmd_wdata_q;
   logic [3:0]            cmd_wmask_q;

   logic [2:0]            d_opcode_q;
   logic [2:0]            size_q;
   logic [SRC_W-1:0]      source_q;
   logic [31:0]           d_data_q;
   logic                  d_err_q;

   logic                  unused_a_param;

   assign unused_a_param = ^bus.io_in_0_a_bits_param;

   // Single FSM: walks IDLE -> CMD -> RSP -> DRSP (or IDLE -> DRSP for
   // unsupported requests) and owns every holding register and handshake flag
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         a_ready_q   <= 1'b1;
         cmd_valid_q <= 1'b0;
         rsp_ready_q <= 1'b0;
         d_valid_q   <= 1'b0;
         addr_q      <= '0;
         cmd_read_q  <= 1'b0;
         cmd_wdata_q <= '0;
         cmd_wmask_q <= '0;
         d_opcode_q  <= '0;
         size_q      <= '0;
         source_q    <= '0;
         d_data_q    <= '0;
         d_err_q     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.io_in_0_a_valid) begin
                  a_ready_q   <= 1'b0;
                  addr_q      <= bus.io_in_0_a_bits_address;
                  size_q      <= bus.io_in_0_a_bits_size;
                  source_q    <= bus.io_in_0_a_bits_source;
                  cmd_read_q  <= (bus.io_in_0_a_bits_opcode == TL_GET);
                  cmd_wdata_q <= (bus.io_in_0_a_bits_opcode == TL_GET) ? 32'h0 : bus.io_in_0_a_bits_data;
                  cmd_wmask_q <= tl_wmask(bus.io_in_0_a_bits_opcode, bus.io_in_0_a_bits_mask);
                  d_opcode_q  <= (bus.io_in_0_a_bits_opcode == TL_GET) ? TL_ACKDATA : TL_ACK;
                  d_data_q    <= 32'h0;
                  if (tl_supported(bus.io_in_0_a_bits_opcode, bus.io_in_0_a_bits_size)) begin
                     d_err_q     <= 1'b0;
                     cmd_valid_q <= 1'b1;
                     state       <= ST_CMD;
                  end else begin
                     d_err_q   <= 1'b1;
                     d_valid_q <= 1'b1;
                     state     <= ST_DRSP;
                  end
               end
            end
            ST_CMD: begin
               if (bus.o_icb_cmd_ready) begin
                  cmd_valid_q <= 1'b0;
                  rsp_ready_q <= 1'b1;
                  state       <= ST_RSP;
               end
            end
            ST_RSP: begin
               if (bus.o_icb_rsp_valid) begin
                  rsp_ready_q <= 1'b0;
                  d_valid_q   <= 1'b1;
                  d_data_q    <= cmd_read_q ? bus.o_icb_rsp_rdata : 32'h0;
                  d_err_q     <= bus.o_icb_rsp_err;
                  state       <= ST_DRSP;
               end
            end
            ST_DRSP: begin
               if (bus.io_in_0_d_ready) begin
                  d_valid_q <= 1'b0;
                  a_ready_q <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.io_in_0_a_ready        = a_ready_q;

   assign bus.o_icb_cmd_valid        = cmd_valid_q;
   assign bus.o_icb_cmd_addr         = ICB_ADDR_W'(addr_q);
   assign bus.o_icb_cmd_read         = cmd_read_q;
   assign bus.o_icb_cmd_wdata        = cmd_wdata_q;
   assign bus.o_icb_cmd_wmask        = cmd_wmask_q;
   assign bus.o_icb_rsp_ready        = rsp_ready_q;

   assign bus.io_in_0_d_valid        = d_valid_q;
   assign bus.io_in_0_d_bits_opcode  = d_opcode_q;
   assign bus.io_in_0_d_bits_param   = 2'd0;
   assign bus.io_in_0_d_bits_size    = size_q;
   assign bus.io_in_0_d_bits_source  = source_q;
   assign bus.io_in_0_d_bits_sink    = 1'b0;
   assign bus.io_in_0_d_bits_addr_lo = addr_q[1:0];
   assign bus.io_in_0_d_bits_data    = d_data_q;
   assign bus.io_in_0_d_bits_error   = d_err_q;

endmodule

// File: tb/tb_n101_tl2icb_bridge.sv
// Bench for the TileLink-to-ICB bridge: directed scenarios with literal
// expectations, followed by randomized TileLink/ICB traffic checked every
// cycle against a transaction-level model of the bridge.
module tb_n101_tl2icb_bridge;

   localparam int SRC_W      = 5;
   localparam int ICB_ADDR_W = 32;

   logic clock = 1'b0;
   logic reset;

   int n_compared   = 0;
   int n_mismatched = 0;

   n101_tl2icb_bridge_if #(.SRC_W(SRC_W), .ICB_ADDR_W(ICB_ADDR_W)) bus_if ();

   n101_tl2icb_bridge #(.ICB_ADDR_W(ICB_ADDR_W), .SRC_W(SRC_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   // Free-running 10-unit clock
   always #5 clock = ~clock;

   // Transaction-level model: one request in flight, tracked by which
   // handshakes it still owes
   bit          model_live = 1'b0;
   bit          m_busy, m_need_cmd, m_need_rsp, m_need_d;
   bit          m_ok, m_err, a_fire;
   logic [2:0]  m_op, m_size;
   logic [4:0]  m_src;
   logic [28:0] m_addr;
   logic [3:0]  m_mask;
   logic [31:0] m_data, m_rdata;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic [2:0] size, input logic [4:0] src,
                                input logic [28:0] addr, input logic [3:0] mask, input logic [31:0] data);
      bus_if.io_in_0_a_valid        = 1'b1;
      bus_if.io_in_0_a_bits_opcode  = op;
      bus_if.io_in_0_a_bits_param   = 3'($urandom_range(0, 7));
      bus_if.io_in_0_a_bits_size    = size;
      bus_if.io_in_0_a_bits_source  = src;
      bus_if.io_in_0_a_bits_address = addr;
      bus_if.io_in_0_a_bits_mask    = mask;
      bus_if.io_in_0_a_bits_data    = data;
   endtask

   function automatic logic [31:0] expWmask(input logic [2:0] op, input logic [3:0] mask);
      if (op == 3'd0) return 32'hF;
      if (op == 3'd1) return {28'h0, mask};
      return 32'h0;
   endfunction

   // Advance the model at each clock edge from the values that edge sees
   always @(posedge clock) begin
      a_fire = 1'b0;
      if (reset) begin
         model_live = 1'b1;
         m_busy     = 1'b0;
         m_need_cmd = 1'b0;
         m_need_rsp = 1'b0;
         m_need_d   = 1'b0;
      end else if (model_live) begin
         if (!m_busy) begin
            if (bus_if.io_in_0_a_valid) begin
               a_fire = 1'b1;
               m_busy = 1'b1;
               m_op   = bus_if.io_in_0_a_bits_opcode;
               m_size = bus_if.io_in_0_a_bits_size;
               m_src  = bus_if.io_in_0_a_bits_source;
               m_addr = bus_if.io_in_0_a_bits_address;
               m_mask = bus_if.io_in_0_a_bits_mask;
               m_data = bus_if.io_in_0_a_bits_data;
               m_ok   = (m_op == 3'd0 || m_op == 3'd1 || m_op == 3'd4) && (m_size < 3'd3);
               if (m_ok) begin
                  m_need_cmd = 1'b1;
               end else begin
                  m_need_d = 1'b1;
                  m_err    = 1'b1;
                  m_rdata  = 32'h0;
               end
            end
         end else if (m_need_cmd) begin
            if (bus_if.o_icb_cmd_ready) begin
               m_need_cmd = 1'b0;
               m_need_rsp = 1'b1;
            end
         end else if (m_need_rsp) begin
            if (bus_if.o_icb_rsp_valid) begin
               m_need_rsp = 1'b0;
               m_need_d   = 1'b1;
               m_rdata    = bus_if.o_icb_rsp_rdata;
               m_err      = bus_if.o_icb_rsp_err;
            end
         end else if (m_need_d) begin
            if (bus_if.io_in_0_d_ready) begin
               m_need_d = 1'b0;
               m_busy   = 1'b0;
            end
         end
      end
   end

   // Compare every DUT output against the model on the falling edge
   always @(negedge clock) begin
      if (model_live) begin
         checkOutput("a_ready", {31'h0, bus_if.io_in_0_a_ready}, {31'h0, !m_busy});
         checkOutput("cmd_valid", {31'h0, bus_if.o_icb_cmd_valid}, {31'h0, m_need_cmd});
         checkOutput("rsp_ready", {31'h0, bus_if.o_icb_rsp_ready}, {31'h0, m_need_rsp});
         checkOutput("d_valid", {31'h0, bus_if.io_in_0_d_valid}, {31'h0, m_need_d});
         if (m_need_cmd) begin
            checkOutput("cmd_addr", bus_if.o_icb_cmd_addr, {3'b000, m_addr});
            checkOutput("cmd_read", {31'h0, bus_if.o_icb_cmd_read}, {31'h0, m_op == 3'd4});
            checkOutput("cmd_wdata", bus_if.o_icb_cmd_wdata, (m_op == 3'd4) ? 32'h0 : m_data);
            checkOutput("cmd_wmask", {28'h0, bus_if.o_icb_cmd_wmask}, expWmask(m_op, m_mask));
         end
         if (m_need_d) begin
            checkOutput("d_opcode", {29'h0, bus_if.io_in_0_d_bits_opcode}, (m_op == 3'd4) ? 32'd1 : 32'd0);
            checkOutput("d_param", {30'h0, bus_if.io_in_0_d_bits_param}, 32'h0);
            checkOutput("d_size", {29'h0, bus_if.io_in_0_d_bits_size}, {29'h0, m_size});
            checkOutput("d_source", {27'h0, bus_if.io_in_0_d_bits_source}, {27'h0, m_src});
            checkOutput("d_sink", {31'h0, bus_if.io_in_0_d_bits_sink}, 32'h0);
            checkOutput("d_addr_lo", {30'h0, bus_if.io_in_0_d_bits_addr_lo}, {30'h0, m_addr[1:0]});
            checkOutput("d_data", bus_if.io_in_0_d_bits_data, (m_ok && m_op == 3'd4) ? m_rdata : 32'h0);
            checkOutput("d_error", {31'h0, bus_if.io_in_0_d_bits_error}, {31'h0, m_err});
         end
      end
   end

   // Directed scenarios followed by randomized traffic
   initial begin
      reset = 1'b1;
      bus_if.io_in_0_a_valid        = 1'b0;
      bus_if.io_in_0_a_bits_opcode  = 3'd0;
      bus_if.io_in_0_a_bits_param   = 3'd0;
      bus_if.io_in_0_a_bits_size    = 3'd0;
      bus_if.io_in_0_a_bits_source  = 5'd0;
      bus_if.io_in_0_a_bits_address = 29'h0;
      bus_if.io_in_0_a_bits_mask    = 4'h0;
      bus_if.io_in_0_a_bits_data    = 32'h0;
      bus_if.io_in_0_d_ready        = 1'b0;
      bus_if.o_icb_cmd_ready        = 1'b0;
      bus_if.o_icb_rsp_valid        = 1'b0;
      bus_if.o_icb_rsp_rdata        = 32'h0;
      bus_if.o_icb_rsp_err          = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkOutput("rst a_ready", {31'h0, bus_if.io_in_0_a_ready}, 32'd1);
      checkOutput("rst d_valid", {31'h0, bus_if.io_in_0_d_valid}, 32'd0);
      checkOutput("rst cmd_valid", {31'h0, bus_if.o_icb_cmd_valid}, 32'd0);
      checkOutput("rst rsp_ready", {31'h0, bus_if.o_icb_rsp_ready}, 32'd0);
      reset = 1'b0;

      // Zero-wait Get
      applyStimulus(3'd4, 3'd2, 5'd3, 29'h1001_4004, 4'hF, 32'h0);
      @(negedge clock);
      bus_if.io_in_0_a_valid = 1'b0;
      bus_if.o_icb_cmd_ready = 1'b1;
      checkOutput("t1 cmd_valid", {31'h0, bus_if.o_icb_cmd_valid}, 32'd1);
      checkOutput("t1 cmd_read", {31'h0, bus_if.o_icb_cmd_read}, 32'd1);
      checkOutput("t1 cmd_addr", bus_if.o_icb_cmd_addr, 32'h1001_4004);
      @(negedge clock);
      bus_if.o_icb_cmd_ready = 1'b0;
      checkOutput("t1 rsp_ready", {31'h0, bus_if.o_icb_rsp_ready}, 32'd1);
      bus_if.o_icb_rsp_valid = 1'b1;
      bus_if.o_icb_rsp_rdata = 32'hDEAD_BEEF;
      bus_if.o_icb_rsp_err   = 1'b0;
      @(negedge clock);
      bus_if.o_icb_rsp_valid = 1'b0;
      checkOutput("t1 d_valid", {31'h0, bus_if.io_in_0_d_valid}, 32'd1);
      checkOutput("t1 d_opcode", {29'h0, bus_if.io_in_0_d_bits_opcode}, 32'd1);
      checkOutput("t1 d_source", {27'h0, bus_if.io_in_0_d_bits_source}, 32'd3);
      checkOutput("t1 d_addr_lo", {30'h0, bus_if.io_in_0_d_bits_addr_lo}, 32'd0);
      checkOutput("t1 d_data", bus_if.io_in_0_d_bits_data, 32'hDEAD_BEEF);
      checkOutput("t1 d_error", {31'h0, bus_if.io_in_0_d_bits_error}, 32'd0);
      bus_if.io_in_0_d_ready = 1'b1;
      @(negedge clock);
      bus_if.io_in_0_d_ready = 1'b0;
      checkOutput("t1 a_ready after", {31'h0, bus_if.io_in_0_a_ready}, 32'd1);

      // PutPartialData with command stalled five cycles
      applyStimulus(3'd1, 3'd0, 5'd7, 29'h0000_0102, 4'b0100, 32'h00AB_0000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         bus_if.io_in_0_a_valid = 1'b0;
         checkOutput("t2 cmd_valid", {31'h0, bus_if.o_icb_cmd_valid}, 32'd1);
         checkOutput("t2 cmd_wmask", {28'h0, bus_if.o_icb_cmd_wmask}, 32'h4);
         checkOutput("t2 cmd_wdata", bus_if.o_icb_cmd_wdata, 32'h00AB_0000);
         checkOutput("t2 cmd_addr", bus_if.o_icb_cmd_addr, 32'h0000_0102);
      end
      bus_if.o_icb_cmd_ready = 1'b1;
      @(negedge clock);
      bus_if.o_icb_cmd_ready = 1'b0;
      bus_if.o_icb_rsp_valid = 1'b1;
      bus_if.o_icb_rsp_rdata = 32'h1234_5678;
      @(negedge clock);
      bus_if.o_icb_rsp_valid = 1'b0;
      checkOutput("t2 d_opcode", {29'h0, bus_if.io_in_0_d_bits_opcode}, 32'd0);
      checkOutput("t2 d_addr_lo", {30'h0, bus_if.io_in_0_d_bits_addr_lo}, 32'd2);
      checkOutput("t2 d_data", bus_if.io_in_0_d_bits_data, 32'h0);
      bus_if.io_in_0_d_ready = 1'b1;
      @(negedge clock);
      bus_if.io_in_0_d_ready = 1'b0;

      // Unsupported Get (size 3) answered directly
      applyStimulus(3'd4, 3'd3, 5'd9, 29'h0000_0040, 4'hF, 32'h0);
      @(negedge clock);
      bus_if.io_in_0_a_valid = 1'b0;
      checkOutput("t3 d_valid", {31'h0, bus_if.io_in_0_d_valid}, 32'd1);
      checkOutput("t3 cmd_valid", {31'h0, bus_if.o_icb_cmd_valid}, 32'd0);
      checkOutput("t3 d_opcode", {29'h0, bus_if.io_in_0_d_bits_opcode}, 32'd1);
      checkOutput("t3 d_error", {31'h0, bus_if.io_in_0_d_bits_error}, 32'd1);
      checkOutput("t3 d_data", bus_if.io_in_0_d_bits_data, 32'h0);
      bus_if.io_in_0_d_ready = 1'b1;
      @(negedge clock);
      bus_if.io_in_0_d_ready = 1'b0;
      checkOutput("t3 a_ready after", {31'h0, bus_if.io_in_0_a_ready}, 32'd1);

      // PutFullData with bus error and D stalled four cycles
      applyStimulus(3'd0, 3'd2, 5'd12, 29'h0000_0200, 4'h0, 32'hCAFE_F00D);
      @(negedge clock);
      bus_if.io_in_0_a_valid = 1'b0;
      checkOutput("t4 cmd_wmask", {28'h0, bus_if.o_icb_cmd_wmask}, 32'hF);
      bus_if.o_icb_cmd_ready = 1'b1;
      @(negedge clock);
      bus_if.o_icb_cmd_ready = 1'b0;
      bus_if.o_icb_rsp_valid = 1'b1;
      bus_if.o_icb_rsp_rdata = 32'hFFFF_FFFF;
      bus_if.o_icb_rsp_err   = 1'b1;
      @(negedge clock);
      bus_if.o_icb_rsp_valid = 1'b0;
      bus_if.o_icb_rsp_err   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checkOutput("t4 d_valid", {31'h0, bus_if.io_in_0_d_valid}, 32'd1);
         checkOutput("t4 d_error", {31'h0, bus_if.io_in_0_d_bits_error}, 32'd1);
         checkOutput("t4 d_data", bus_if.io_in_0_d_bits_data, 32'h0);
         checkOutput("t4 a_ready", {31'h0, bus_if.io_in_0_a_ready}, 32'd0);
         @(negedge clock);
      end
      bus_if.io_in_0_d_ready = 1'b1;
      @(negedge clock);
      bus_if.io_in_0_d_ready = 1'b0;
      checkOutput("t4 a_ready after", {31'h0, bus_if.io_in_0_a_ready}, 32'd1);

      // Back-to-back requests with a_valid held high
      applyStimulus(3'd4, 3'd2, 5'd1, 29'h0000_1000, 4'hF, 32'h0);
      @(negedge clock);
      applyStimulus(3'd0, 3'd2, 5'd2, 29'h0000_2004, 4'hF, 32'h5555_AAAA);
      bus_if.o_icb_cmd_ready = 1'b1;
      checkOutput("t5 a_ready busy1", {31'h0, bus_if.io_in_0_a_ready}, 32'd0);
      @(negedge clock);
      bus_if.o_icb_cmd_ready = 1'b0;
      bus_if.o_icb_rsp_valid = 1'b1;
      bus_if.o_icb_rsp_rdata = 32'h0BAD_CAFE;
      checkOutput("t5 a_ready busy2", {31'h0, bus_if.io_in_0_a_ready}, 32'd0);
      @(negedge clock);
      bus_if.o_icb_rsp_valid = 1'b0;
      checkOutput("t5 d_data1", bus_if.io_in_0_d_bits_data, 32'h0BAD_CAFE);
      checkOutput("t5 d_source1", {27'h0, bus_if.io_in_0_d_bits_source}, 32'd1);
      checkOutput("t5 a_ready busy3", {31'h0, bus_if.io_in_0_a_ready}, 32'd0);
      bus_if.io_in_0_d_ready = 1'b1;
      @(negedge clock);
      bus_if.io_in_0_d_ready = 1'b0;
      checkOutput("t5 a_ready idle", {31'h0, bus_if.io_in_0_a_ready}, 32'd1);
      checkOutput("t5 cmd_valid idle", {31'h0, bus_if.o_icb_cmd_valid}, 32'd0);
      @(negedge clock);
      bus_if.io_in_0_a_valid = 1'b0;
      checkOutput("t5 cmd_wdata2", bus_if.o_icb_cmd_wdata, 32'h5555_AAAA);
      checkOutput("t5 cmd_addr2", bus_if.o_icb_cmd_addr, 32'h0000_2004);
      checkOutput("t5 cmd_read2", {31'h0, bus_if.o_icb_cmd_read}, 32'd0);
      bus_if.o_icb_cmd_ready = 1'b1;
      @(negedge clock);
      bus_if.o_icb_cmd_ready = 1'b0;
      bus_if.o_icb_rsp_valid = 1'b1;
      bus_if.o_icb_rsp_rdata = 32'h7777_7777;
      @(negedge clock);
      bus_if.o_icb_rsp_valid = 1'b0;
      checkOutput("t5 d_opcode2", {29'h0, bus_if.io_in_0_d_bits_opcode}, 32'd0);
      checkOutput("t5 d_source2", {27'h0, bus_if.io_in_0_d_bits_source}, 32'd2);
      checkOutput("t5 d_data2", bus_if.io_in_0_d_bits_data, 32'h0);
      bus_if.io_in_0_d_ready = 1'b1;
      @(negedge clock);
      bus_if.io_in_0_d_ready = 1'b0;

      // Reset while waiting for the ICB response
      applyStimulus(3'd4, 3'd2, 5'd4, 29'h0000_0300, 4'hF, 32'h0);
      @(negedge clock);
      bus_if.io_in_0_a_valid = 1'b0;
      bus_if.o_icb_cmd_ready = 1'b1;
      @(negedge clock);
      bus_if.o_icb_cmd_ready = 1'b0;
      checkOutput("t6 rsp_ready", {31'h0, bus_if.o_icb_rsp_ready}, 32'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checkOutput("t6 a_ready", {31'h0, bus_if.io_in_0_a_ready}, 32'd1);
      checkOutput("t6 cmd_valid", {31'h0, bus_if.o_icb_cmd_valid}, 32'd0);
      checkOutput("t6 rsp_ready after", {31'h0, bus_if.o_icb_rsp_ready}, 32'd0);
      checkOutput("t6 d_valid", {31'h0, bus_if.io_in_0_d_valid}, 32'd0);
      @(negedge clock);
      checkOutput("t6 d_valid later", {31'h0, bus_if.io_in_0_d_valid}, 32'd0);

      // Randomized traffic; the TileLink master holds a request until accepted
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clock);
         reset = ($urandom_range(0, 299) == 0);
         if (!bus_if.io_in_0_a_valid || a_fire) begin
            logic [2:0] op;
            logic [2:0] size;
            int         pick;
            pick = $urandom_range(0, 9);
            if (pick < 3) op = 3'd0;
            else if (pick < 6) op = 3'd1;
            else if (pick < 9) op = 3'd4;
            else op = 3'($urandom_range(0, 7));
            size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            applyStimulus(op, size, 5'($urandom_range(0, 31)), 29'($urandom),
                          4'($urandom_range(0, 15)), $urandom);
            bus_if.io_in_0_a_valid = ($urandom_range(0, 2) != 0);
         end
         bus_if.o_icb_cmd_ready = ($urandom_range(0, 1) == 1);
         bus_if.o_icb_rsp_valid = m_need_rsp && ($urandom_range(0, 2) != 0);
         bus_if.o_icb_rsp_rdata = $urandom;
         bus_if.o_icb_rsp_err   = ($urandom_range(0, 3) == 0);
         bus_if.io_in_0_d_ready = ($urandom_range(0, 4) < 3);
      end

      @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
